// File: rtl/clock_display_scan_if.sv
// Time-digit inputs and 7-segment display outputs of the scan block.
// master = digit source / board side, slave = clock_display_scan.
interface clock_display_scan_if;
   logic       enb;
   logic [2:0] h1;
   logic [3:0] h0;
   logic [2:0] m1;
   logic [3:0] m0;
   logic [6:0] seg;
   logic [3:0] dig_sel;
   logic       colon;
   logic       frame_tc;
   logic       err;

   modport master (
      output enb, h1, h0, m1, m0,
      input  seg, dig_sel, colon, frame_tc, err
   );

   modport slave (
      input  enb, h1, h0, m1, m0,
      output seg, dig_sel, colon, frame_tc, err
   );
endinterface

// File: rtl/clock_display_scan.sv
// Multiplexed 4-digit 7-segment scan of h1h0:m1m0 with per-frame snapshot.
// Optional DISP_COLON_BLINK_EN: colon blinks every BLINK_FRAMES frames.
module clock_display_scan #(
   parameter int SCAN_DIV     = 4,
   parameter int BLINK_FRAMES = 8
) (
   input logic                  clk,
   input logic                  clr_,
   clock_display_scan_if.slave  bus
);
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

   if (SCAN_DIV < 1 || BLINK_FRAMES < 1) begin : g_bad_cfg
   end

   logic [PW-1:0] presc_q, presc_d;
   logic [1:0]    idx_q, idx_d;
   logic          load_q, load_d;
   logic [2:0]    h1_q, h1_d, m1_q, m1_d;
   logic [3:0]    h0_q, h0_d, m0_q, m0_d;
   logic          err_q, err_d;
   logic [6:0]    seg_q, seg_d;
   logic [3:0]    dig_q, dig_d;
   logic          ftc_q, ftc_d;
   logic          colon_q, colon_d;

   logic          tick, cap, in_bad, blank;
   logic [3:0]    cur, lim;

   function automatic logic [6:0] dec(input logic [3:0] d);
      case (d)
         4'd0:    dec = 7'h3F;
         4'd1:    dec = 7'h06;
         4'd2:    dec = 7'h5B;
         4'd3:    dec = 7'h4F;
         4'd4:    dec = 7'h66;
         4'd5:    dec = 7'h6D;
         4'd6:    dec = 7'h7D;
         4'd7:    dec = 7'h07;
         4'd8:    dec = 7'h7F;
         4'd9:    dec = 7'h6F;
         default: dec = 7'h00;
      endcase
   endfunction

   assign tick   = bus.enb & (presc_q == PMAX);
   assign cap    = bus.enb & (load_q | (tick & (idx_q == 2'd3)));
   assign in_bad = (bus.m0 > 4'd9) | (bus.m1 > 3'd5) |
                   (bus.h0 > 4'd9) | (bus.h1 > 3'd2);

   always_comb begin
      cur   = m0_q;
      lim   = 4'd9;
      blank = 1'b0;
      unique case (idx_q)
         2'd0: begin
            cur = m0_q;
            lim = 4'd9;
         end
         2'd1: begin
            cur = {1'b0, m1_q};
            lim = 4'd5;
         end
         2'd2: begin
            cur = h0_q;
            lim = 4'd9;
         end
         2'd3: begin
            cur   = {1'b0, h1_q};
            lim   = 4'd2;
            blank = (h1_q == 3'd0);
         end
      endcase
   end

   always_comb begin
      presc_d = presc_q;
      idx_d   = idx_q;
      load_d  = load_q;
      h1_d    = h1_q;
      h0_d    = h0_q;
      m1_d    = m1_q;
      m0_d    = m0_q;
      err_d   = err_q;
      seg_d   = seg_q;
      dig_d   = dig_q;
      ftc_d   = tick & (idx_q == 2'd3);
      if (bus.enb) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
         if (tick) idx_d = idx_q + 2'd1;
         load_d = 1'b0;
         // display lags idx by one cycle; snapshot swaps with the 3->0 wrap
         seg_d  = (blank || cur > lim) ? 7'h00 : dec(cur);
         dig_d  = 4'b0001 << idx_q;
      end
      if (cap) begin
         h1_d  = bus.h1;
         h0_d  = bus.h0;
         m1_d  = bus.m1;
         m0_d  = bus.m0;
         err_d = in_bad;
      end
   end

`ifdef DISP_COLON_BLINK_EN
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FW-1:0] FMAX = FW'(BLINK_FRAMES - 1);

   logic [FW-1:0] fc_q, fc_d;

   always_comb begin
      fc_d    = fc_q;
      colon_d = colon_q;
      if (bus.enb && ftc_q) begin
         if (fc_q == FMAX) begin
            fc_d    = '0;
            colon_d = ~colon_q;
         end else begin
            fc_d = fc_q + FW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge clr_) begin
      if (!clr_) fc_q <= '0;
      else       fc_q <= fc_d;
   end
`else
   assign colon_d = 1'b1;
`endif

   always_ff @(posedge clk or negedge clr_) begin
      if (!clr_) begin
         presc_q <= '0;
         idx_q   <= 2'd0;
         load_q  <= 1'b1;
         h1_q    <= 3'd0;
         h0_q    <= 4'd0;
         m1_q    <= 3'd0;
         m0_q    <= 4'd0;
         err_q   <= 1'b0;
         seg_q   <= 7'h00;
         dig_q   <= 4'b0000;
         ftc_q   <= 1'b0;
         colon_q <= 1'b0;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         load_q  <= load_d;
         h1_q    <= h1_d;
         h0_q    <= h0_d;
         m1_q    <= m1_d;
         m0_q    <= m0_d;
         err_q   <= err_d;
         seg_q   <= seg_d;
         dig_q   <= dig_d;
         ftc_q   <= ftc_d;
         colon_q <= colon_d;
      end
   end

   assign bus.seg      = seg_q;
   assign bus.dig_sel  = dig_q;
   assign bus.colon    = colon_q;
   assign bus.frame_tc = ftc_q & bus.enb;
   assign bus.err      = err_q;
endmodule
